// File: rtl/arith.sv
// -----------------------------------------------------------------------------
// arith -- registered 8-bit arithmetic/logic unit.
//
// Takes two operands and an opcode and produces one result word plus status
// flags exactly one clock after in_valid is sampled high. There is no internal
// multi-cycle state. A new operation can be accepted on every cycle.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   a, b       in   operands (unsigned; two's complement for ovf)
//   op         in   000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR,
//                   101 MUL, 110 MIN, 111 MAX
//   in_valid   in   operands/opcode sampled when high
//   out        out  registered result
//   out_valid  out  one-cycle pulse per new result
//   carry      out  carry / borrow / product-high-nonzero
//   zero       out  registered out == 0
//   ovf        out  signed overflow (ADD/SUB only)
//
// Build option:
//   ARITH_SAT_EN  when defined, ADD and MUL clamp to all-ones on carry and
//                 SUB clamps to zero on borrow. carry and ovf report the raw
//                 (unclamped) condition.
// -----------------------------------------------------------------------------
module arith #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             carry,
   output logic             zero,
   output logic             ovf
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_MUL = 3'b101;
   localparam logic [2:0] OP_MIN = 3'b110;
   localparam logic [2:0] OP_MAX = 3'b111;

`ifdef ARITH_SAT_EN
   // Clamp to the largest unsigned value when the raw result overflowed.
   function automatic logic [WIDTH-1:0] sat_hi(input logic [WIDTH-1:0] v,
                                               input logic             c);
      return c ? {WIDTH{1'b1}} : v;
   endfunction

   // Clamp to zero when the raw subtraction borrowed.
   function automatic logic [WIDTH-1:0] sat_lo(input logic [WIDTH-1:0] v,
                                               input logic             c);
      return c ? {WIDTH{1'b0}} : v;
   endfunction
`endif

   logic [WIDTH:0]     w_sum;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_borrow;
   logic               w_prod_hi;
   logic               w_add_ovf;
   logic               w_sub_ovf;
   logic               w_a_lt_b;
   logic [WIDTH-1:0]   w_res;
   logic               w_carry;
   logic               w_ovf;

   // Widen before the operation so the carry/borrow and high product bits survive.
   assign w_sum     = {1'b0, a} + {1'b0, b};
   assign w_diff    = {1'b0, a} - {1'b0, b};
   assign w_prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign w_borrow  = w_diff[WIDTH];
   assign w_prod_hi = |w_prod[2*WIDTH-1:WIDTH];
   assign w_a_lt_b  = (a < b);

   // ADD overflows when both operands share a sign the result does not;
   // SUB overflows when the operands differ in sign and the result takes b's sign.
   assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
   assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

   always_comb begin
      w_res   = '0;
      w_carry = 1'b0;
      w_ovf   = 1'b0;
      unique case (op)
         OP_ADD: begin
            w_carry = w_sum[WIDTH];
            w_ovf   = w_add_ovf;
`ifdef ARITH_SAT_EN
            w_res   = sat_hi(w_sum[WIDTH-1:0], w_sum[WIDTH]);
`else
            w_res   = w_sum[WIDTH-1:0];
`endif
         end
         OP_SUB: begin
            w_carry = w_borrow;
            w_ovf   = w_sub_ovf;
`ifdef ARITH_SAT_EN
            w_res   = sat_lo(w_diff[WIDTH-1:0], w_borrow);
`else
            w_res   = w_diff[WIDTH-1:0];
`endif
         end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_MUL: begin
            w_carry = w_prod_hi;
`ifdef ARITH_SAT_EN
            w_res   = sat_hi(w_prod[WIDTH-1:0], w_prod_hi);
`else
            w_res   = w_prod[WIDTH-1:0];
`endif
         end
         OP_MIN: w_res = w_a_lt_b ? a : b;
         OP_MAX: w_res = w_a_lt_b ? b : a;
         default: w_res = '0;
      endcase
   end

   // ---- result register: reset wins over in_valid, idle cycles hold ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out       <= '0;
         carry     <= 1'b0;
         zero      <= 1'b1;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else if (in_valid) begin
         out       <= w_res;
         carry     <= w_carry;
         zero      <= (w_res == '0);
         ovf       <= w_ovf;
         out_valid <= 1'b1;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_arith.sv
module tb_arith;

   typedef struct {
      logic [7:0] out;
      logic       c;
      logic       z;
      logic       v;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] a, b;
   logic [2:0] op;
   logic       in_valid;
   logic [7:0] out;
   logic       out_valid, carry, zero, ovf;

   exp_t q[$];
   exp_t last_exp;
   int   checks = 0;
   int   errors = 0;
   int   pushes = 0;
   int   pops   = 0;

   arith #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid),
      .out(out), .out_valid(out_valid), .carry(carry), .zero(zero), .ovf(ovf)
   );

   always #5 clk = ~clk;

   // Reference model: plain integer arithmetic from the opcode definitions.
   function automatic exp_t model(input int ia, input int ib, input int iop);
      exp_t e;
      int   r, sa, sb, sr, o;
      bit   c, v;
      sa = (ia >= 128) ? ia - 256 : ia;
      sb = (ib >= 128) ? ib - 256 : ib;
      c = 0; v = 0; o = 0;
      case (iop)
         0: begin
            r = ia + ib; c = (r > 255); o = r % 256;
            sr = sa + sb; v = (sr > 127) || (sr < -128);
`ifdef ARITH_SAT_EN
            if (c) o = 255;
`endif
         end
         1: begin
            r = ia - ib; c = (ia < ib); o = (r + 256) % 256;
            sr = sa - sb; v = (sr > 127) || (sr < -128);
`ifdef ARITH_SAT_EN
            if (c) o = 0;
`endif
         end
         2: o = ia & ib;
         3: o = ia | ib;
         4: o = ia ^ ib;
         5: begin
            r = ia * ib; c = (r > 255); o = r % 256;
`ifdef ARITH_SAT_EN
            if (c) o = 255;
`endif
         end
         6: o = (ia < ib) ? ia : ib;
         default: o = (ia > ib) ? ia : ib;
      endcase
      e.out = 8'(o);
      e.c   = c;
      e.v   = v;
      e.z   = (o == 0);
      return e;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus; valid operations outside reset are scoreboarded.
   task automatic drive(input int ia, input int ib, input int iop, input bit v);
      @(negedge clk);
      a = 8'(ia); b = 8'(ib); op = 3'(iop); in_valid = v;
      if (v && rst_n) begin
         last_exp = model(ia, ib, iop);
         q.push_back(last_exp);
         pushes++;
      end
   endtask

   // Idle cycles: no pulse, registered outputs hold the last result.
   task automatic idle_check(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b0;
         a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
         @(posedge clk); #1;
         chk("hold_valid", int'(out_valid), 0);
         chk("hold_out",   int'(out),   int'(last_exp.out));
         chk("hold_carry", int'(carry), int'(last_exp.c));
         chk("hold_zero",  int'(zero),  int'(last_exp.z));
         chk("hold_ovf",   int'(ovf),   int'(last_exp.v));
      end
   endtask

   // Monitor: every out_valid pulse pops one expected result.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 1, 0);
            end else begin
               e = q.pop_front();
               pops++;
               chk("out",   int'(out),   int'(e.out));
               chk("carry", int'(carry), int'(e.c));
               chk("zero",  int'(zero),  int'(e.z));
               chk("ovf",   int'(ovf),   int'(e.v));
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
      repeat (3) drive(0, 0, 0, 0);
      @(posedge clk); #1;
      chk("rst_out",   int'(out), 0);
      chk("rst_zero",  int'(zero), 1);
      chk("rst_carry", int'(carry), 0);
      chk("rst_ovf",   int'(ovf), 0);
      chk("rst_valid", int'(out_valid), 0);

      // Directed operations, back-to-back from the first cycle after release.
      @(negedge clk); rst_n = 1'b1;
      a = 0; b = 0; op = 0; in_valid = 1;
      last_exp = model(0, 0, 0); q.push_back(last_exp); pushes++;
      drive(200, 100, 0, 1);
      drive(100, 100, 0, 1);
      drive(5,   10,  1, 1);
      drive(16,  16,  5, 1);
      drive(12,  10,  5, 1);
      for (int k = 2; k <= 7; k++) begin
         if (k != 5) drive(8'hF0, 8'h3C, k, 1);
      end
      drive(8'h80, 8'h01, 1, 1);
      drive(8'h7F, 8'h01, 0, 1);
      idle_check(3);

      // Valid op during reset is discarded.
      @(negedge clk);
      rst_n = 1'b0; a = 8'd1; b = 8'd2; op = 3'd0; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("rstov_out",   int'(out), 0);
      chk("rstov_valid", int'(out_valid), 0);
      chk("rstov_zero",  int'(zero), 1);
      @(negedge clk);
      rst_n = 1'b1; in_valid = 1'b0;
      last_exp.out = 8'd0; last_exp.c = 0; last_exp.z = 1; last_exp.v = 0;
      idle_check(3);

      // Random traffic with gaps.
      for (int i = 0; i < 400; i++) begin
         drive(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      end
      idle_check(2);

      chk("pulse_count", pops, pushes);
      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
